// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main control state machine of the multi-cycle core. Sequences fetch, decode,
// execute, memory and writeback for the instruction held in the instruction
// register. It drives the datapath mux selects and write enables, and decodes
// the immediate-format controls used by the immediate extender.
//
// Optional build macro: UNDEF_TRAP_EN
//   defined   : an undefined encoding seen in DECODE parks the FSM in TRAP
//               (all enables low, Undef=1) until reset; adds the Undef port.
//   undefined : an undefined encoding is treated as a NOP (DECODE -> FETCH).
//
// Parameters:
//   RESET_STATE  state encoding entered on reset (FETCH)
//   MAX_WAIT     memory wait cycles tolerated before MemTimeout sets
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   Op         in   [1:0] instruction bits [27:26]
//   Funct      in   [5:0] instruction bits [25:20] (Funct[5]=I, Funct[0]=S/L)
//   Rd         in   [3:0] instruction bits [15:12]
//   MemReady   in   memory completed the current access this cycle
//   IRWrite    out  load instruction register
//   AdrSrc     out  memory address select (0=PC, 1=ALU result reg)
//   ALUSrcA    out  [1:0] ALU A select (00=Rn, 01=PC, 10=zero)
//   ALUSrcB    out  [1:0] ALU B select (00=Rm, 01=ExtImm, 10=4)
//   ResultSrc  out  [1:0] result select (00=ALUOut, 01=Data, 10=ALU direct)
//   ALUOp      out  ALU decoder enable
//   NextPC     out  PC write (non-branch)
//   Branch     out  branch candidate
//   RegW       out  register-file write request
//   MemW       out  memory write request
//   ImmSrc     out  [1:0] immediate format
//   IsMovt     out  MOVT qualifier
//   IsMovm     out  MOVM qualifier
//   MemTimeout out  sticky: a memory wait reached MAX_WAIT
//   Undef      out  (UNDEF_TRAP_EN only) FSM parked on an undefined encoding
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter logic [3:0]  RESET_STATE = 4'd0,
  parameter int unsigned MAX_WAIT    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       Branch,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] ImmSrc,
  output logic       IsMovt,
  output logic       IsMovm,
  output logic       MemTimeout
`ifdef UNDEF_TRAP_EN
  ,
  output logic       Undef
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECUTER = 4'd2,
    S_EXECUTEI = 4'd3,
    S_ALUWB    = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMREAD  = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWRITE = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q;
  logic            timeout_q;
  logic            wait_state;
  logic            stall;
  logic            cnt_at_max;
  logic            undef_enc;
  logic            rd_is_pc;
  logic            unused_funct;

  // Funct[3:1] carry no control meaning for this FSM.
  assign unused_funct = ^Funct[3:1];

  // Immediate-format decode is purely a function of the instruction bits.
  assign ImmSrc    = Op;
  assign IsMovt    = (Op == 2'b11) && (Funct[5:4] == 2'b01);
  assign IsMovm    = (Op == 2'b11) && (Funct[5:4] == 2'b10);
  assign undef_enc = (Op == 2'b11) && (Funct[5:4] == 2'b11);
  assign rd_is_pc  = (Rd == 4'hF);

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);
  assign stall      = wait_state && !MemReady;
  assign cnt_at_max = (wait_cnt_q >= MAX_CNT);

  // The flag is visible as soon as the count reaches the limit and latched
  // on the following edge, so it survives even if the access completes then.
  assign MemTimeout = timeout_q | cnt_at_max;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (Op == 2'b01)      state_d = S_MEMADR;
        else if (Op == 2'b10) state_d = S_BRANCH;
        else if (Op == 2'b11) begin
          if (!undef_enc)     state_d = S_EXECUTEI;
          else begin
`ifdef UNDEF_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        end else              state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef UNDEF_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= state_t'(RESET_STATE);
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_q | cnt_at_max;
      if (state_d != state_q)
        wait_cnt_q <= '0;
      else if (stall && !cnt_at_max)
        wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

  // Moore output decode (FETCH's IRWrite/NextPC also qualify on MemReady)
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
`ifdef UNDEF_TRAP_EN
    Undef     = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // Reset holds the PC and IR still even though the state reads FETCH.
        IRWrite   = MemReady && !reset;
        NextPC    = MemReady && !reset;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        // MOV-family immediates pass ExtImm through an A=0 add.
        if (Op == 2'b11) ALUSrcA = 2'b10;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        if (rd_is_pc) NextPC = 1'b1;
        else          RegW   = 1'b1;
      end
      S_MEMADR:  ALUSrcB = 2'b01;
      S_MEMREAD: AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        if (rd_is_pc) NextPC = 1'b1;
        else          RegW   = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
`ifdef UNDEF_TRAP_EN
      S_TRAP: Undef = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine of the multi-cycle core. It sequences fetch, decode, execute, memory and writeback for each instruction held in the instruction register. It drives the datapath mux selects and write enables, and decodes the immediate-format controls (ImmSrc, IsMovt, IsMovm) consumed by the immediate extender. One instruction completes every 3–5 cycles, plus memory wait states.

Parameters:
RESET_STATE, 4'd0, state encoding entered on reset (FETCH)
MAX_WAIT, 8, memory wait cycles tolerated before the MemTimeout flag sets

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  2  instruction register bits [27:26]
Funct  in  6  instruction register bits [25:20]; Funct[5] = I bit, Funct[0] = S/L bit
Rd  in  4  instruction register bits [15:12]
MemReady  in  1  memory has completed the current read or write this cycle
IRWrite  out  1  load the instruction register
AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
ALUSrcA  out  2  ALU A select: 00 = Rn, 01 = PC, 10 = zero
ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = const 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU direct
ALUOp  out  1  ALU decoder enable
NextPC  out  1  PC write (non-branch)
Branch  out  1  branch candidate (condition logic gates the PC write)
RegW  out  1  register-file write request
MemW  out  1  memory write request
ImmSrc  out  2  immediate format for the extender
IsMovt  out  1  MOVT qualifier
IsMovm  out  1  MOVM qualifier
MemTimeout  out  1  sticky flag: a wait exceeded MAX_WAIT

Behaviour:
- Reset (asynchronous, active-high):
  - State = FETCH, wait counter = 0, MemTimeout = 0.
  - All outputs take their FETCH values, except NextPC = 0 and IRWrite = 0 while reset is high.
- State register and wait counter update on the rising clock edge. All outputs are combinational from state (Moore), except ImmSrc/IsMovt/IsMovm, which decode Op/Funct combinationally in every state.
- Immediate decode:
  - Op=00 → ImmSrc=00; Op=01 → 01; Op=10 → 10; Op=11 → 11.
  - Op=11: Funct[5:4] = 00 MOV, 01 MOVT (IsMovt=1), 10 MOVM (IsMovm=1), 11 undefined.
  - IsMovt and IsMovm are never both 1.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Holds while MemReady=0. On MemReady=1: IRWrite=1, NextPC=1, go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (PC+8 precompute). Next state:
    - Op=01 → MEMADR
    - Op=10 → BRANCH
    - Op=11 with Funct[5:4]≠11 → EXECUTEI
    - Op=00 → EXECUTEI if Funct[5]=1, else EXECUTER
    - Undefined → see Optional Feature
  - EXECUTER: ALUSrcB=00, ALUOp=1, go to ALUWB.
  - EXECUTEI: ALUSrcB=01, ALUOp=1. For Op=11, ALUSrcA=10 (pass ExtImm). Go to ALUWB.
  - ALUWB: RegW=1, ResultSrc=00, go to FETCH.
  - MEMADR: ALUSrcB=01, go to MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Holds until MemReady=1, then go to MEMWB.
  - MEMWB: RegW=1, ResultSrc=01, go to FETCH.
  - MEMWRITE: AdrSrc=1, MemW=1 held until MemReady=1, then go to FETCH.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, go to FETCH.
- Writes to R15:
  - In ALUWB or MEMWB with Rd=4'hF: RegW=0 and NextPC=1 (result written to the PC).
- Wait counter:
  - Increments each cycle spent stalled in FETCH, MEMREAD or MEMWRITE; clears on any state change.
  - When the count reaches MAX_WAIT, MemTimeout sets and stays set until reset. The FSM keeps waiting; it never aborts a transaction.
  - The counter saturates; it never wraps.
- MemReady=1 arriving in the same cycle the count hits MAX_WAIT: the transition occurs and MemTimeout still sets.
- Reset asserted mid-instruction: immediate return to FETCH. A pending MemW deasserts asynchronously.

Optional Feature:
- Macro: UNDEF_TRAP_EN.
- Defined: an undefined encoding in DECODE goes to TRAP. TRAP drives all enables to 0, asserts an extra output Undef=1, and holds until reset.
- Not defined: an undefined encoding goes from DECODE straight to FETCH as a NOP. No Undef port exists.

Test Plan:
- Data-processing register (Op=00, Funct=000100), MemReady=1 throughout → FETCH, DECODE, EXECUTER, ALUWB; RegW=1 only in cycle 4; next FETCH in cycle 5.
- MOVT (Op=11, Funct=010000) → ImmSrc=11, IsMovt=1, IsMovm=0; path passes through EXECUTEI with ALUSrcA=10, ALUSrcB=01.
- LDR (Op=01, Funct[0]=1) with MemReady low for 3 cycles in MEMREAD → MEMREAD held 4 cycles, then MEMWB with ResultSrc=01 and RegW=1.
- MEMWRITE with MemReady low for 10 cycles (MAX_WAIT=8) → MemTimeout=1 after the 8th stall cycle; MemW stays high until MemReady arrives; flag stays set afterwards.
- ALU op with Rd=15 → ALUWB asserts NextPC=1 and RegW=0.
- Reset asserted during MEMWRITE → MemW=0 in the same cycle, state FETCH; with UNDEF_TRAP_EN, Op=11/Funct[5:4]=11 → Undef=1 held until reset.
